sram_rd_streamer: RTL



---
 rtl/npu_sram_pkg.sv | 25 ++
 rtl/sram_rd_fifo.sv | 70 +++++++
 rtl/sram_rd_streamer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/npu_sram_pkg.sv
// Shared types for the SRAM read streamer: FSM states, FIFO depth and the
// latched read descriptor (field widths match the default streamer configuration).
package npu_sram_pkg;

    localparam int RD_FIFO_DEPTH = 4;
    localparam int RD_ADDRW      = 12;
    localparam int RD_LENW       = 16;
    localparam int RD_CHW        = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [RD_ADDRW-1:0] base;
        logic [RD_LENW-1:0]  beats;
        logic [RD_CHW-1:0]   channels;
        logic [RD_ADDRW-1:0] ch_stride;
        logic [RD_ADDRW-1:0] beat_stride;
    } rd_desc_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO holding returned SRAM words plus their last-beat flag.
// Storage is not reset; the read port is forced to zero while the FIFO is empty.
module sram_rd_fifo
    import npu_sram_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int DEPTH = RD_FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       wr_last_i,
    input  logic                       rd_en_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_last_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [WIDTH:0]    mem_q [DEPTH];
    logic [WIDTH:0]    mem_d [DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en_i && (count_q != CNTW'(DEPTH));
    assign rd_ok = rd_en_i && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = {wr_last_i, wr_data_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNTW'(wr_ok) - CNTW'(rd_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign valid_o   = (count_q != '0);
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign rd_last_o = valid_o & mem_q[rd_ptr_q][WIDTH];
    assign count_o   = count_q;

endmodule

// File: rtl/sram_rd_streamer.sv
// Strided tensor-read streamer: descriptor -> multi-lane SRAM reads -> valid/ready stream.
// Optional stall-cycle counter port is enabled with `define SRAM_RD_PERF_EN.
module sram_rd_streamer
    import npu_sram_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int N_ENTRIES          = 4096,
    parameter int ADDRW              = $clog2(N_ENTRIES),
    parameter int MAX_CHANNELS       = 64,
    parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS+1),
    parameter int LEN_WIDTH          = 16
) (
`ifdef SRAM_RD_PERF_EN
    output logic [31:0]                        perf_stall_cycles_o,
`endif
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [ADDRW-1:0]                   base_addr_i,
    input  logic [LEN_WIDTH-1:0]               num_beats_i,
    input  logic [NUM_CHANNELS_WIDTH-1:0]      num_channels_i,
    input  logic [ADDRW-1:0]                   ch_stride_i,
    input  logic [ADDRW-1:0]                   beat_stride_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               sram_en_o,
    output logic                               sram_we_o,
    output logic [NUM_CHANNELS_WIDTH-1:0]      sram_num_channels_o,
    output logic [ADDRW*MAX_CHANNELS-1:0]      sram_addr_o,
    input  logic [DATA_WIDTH*MAX_CHANNELS-1:0] sram_data_i,
    input  logic                               sram_ready_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [DATA_WIDTH*MAX_CHANNELS-1:0] m_data_o,
    output logic                               m_last_o
);

    localparam int CNTW = $clog2(RD_FIFO_DEPTH+1);

    rd_state_t                         state_q, state_d;
    rd_desc_t                          desc_q, desc_d;
    logic [ADDRW-1:0]                  beat_off_q, beat_off_d;
    logic [LEN_WIDTH-1:0]              issued_q, issued_d;
    logic [LEN_WIDTH-1:0]              written_q, written_d;
    logic [1:0]                        outstanding_q, outstanding_d;

    logic [ADDRW-1:0]                  lane_addr [MAX_CHANNELS];
    logic [MAX_CHANNELS-1:0]           lane_en;
    logic [CNTW-1:0]                   fifo_count;
    logic [3:0]                        inflight;
    logic                              issue;
    logic                              fifo_wr;
    logic                              fifo_rd;
    logic                              wr_last;
    logic [DATA_WIDTH*MAX_CHANNELS-1:0] wr_data;

    // Lane addresses relative to beat 0 are fixed for a descriptor; an adder
    // chain replaces the c*ch_stride products.
    always_comb begin
        logic [ADDRW-1:0] acc;
        acc = desc_q.base;
        for (int c = 0; c < MAX_CHANNELS; c++) begin
            lane_addr[c] = acc;
            lane_en[c]   = (c < int'(desc_q.channels));
            acc          = acc + desc_q.ch_stride;
        end
    end

    always_comb begin
        sram_addr_o = '0;
        wr_data     = '0;
        for (int c = 0; c < MAX_CHANNELS; c++) begin
            if (lane_en[c]) begin
                sram_addr_o[c*ADDRW +: ADDRW]          = lane_addr[c] + beat_off_q;
                wr_data[c*DATA_WIDTH +: DATA_WIDTH]    = sram_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign inflight = {1'b0, fifo_count} + 4'(outstanding_q);
    assign issue    = (state_q == RUN) && (issued_q < desc_q.beats) &&
                      (inflight < 4'(RD_FIFO_DEPTH));
    assign fifo_wr  = sram_ready_i && (outstanding_q != 2'd0);
    assign fifo_rd  = m_valid_o && m_ready_i;
    assign wr_last  = (written_q == desc_q.beats - LEN_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        desc_d        = desc_q;
        beat_off_d    = beat_off_q;
        issued_d      = issued_q;
        written_d     = written_q + LEN_WIDTH'(fifo_wr);
        outstanding_d = outstanding_q + 2'(issue) - 2'(fifo_wr);
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    desc_d.base        = base_addr_i;
                    desc_d.beats       = num_beats_i;
                    desc_d.channels    = (num_channels_i > NUM_CHANNELS_WIDTH'(MAX_CHANNELS)) ?
                                         NUM_CHANNELS_WIDTH'(MAX_CHANNELS) : num_channels_i;
                    desc_d.ch_stride   = ch_stride_i;
                    desc_d.beat_stride = beat_stride_i;
                    beat_off_d         = '0;
                    issued_d           = '0;
                    written_d          = '0;
                    state_d            = (num_beats_i == '0 || num_channels_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    beat_off_d = beat_off_q + desc_q.beat_stride;
                    issued_d   = issued_q + LEN_WIDTH'(1);
                    if (issued_q == desc_q.beats - LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_rd && m_last_o) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            desc_q        <= '0;
            beat_off_q    <= '0;
            issued_q      <= '0;
            written_q     <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            desc_q        <= desc_d;
            beat_off_q    <= beat_off_d;
            issued_q      <= issued_d;
            written_q     <= written_d;
            outstanding_q <= outstanding_d;
        end
    end

    sram_rd_fifo #(
        .WIDTH (DATA_WIDTH*MAX_CHANNELS),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_data),
        .wr_last_i (wr_last),
        .rd_en_i   (fifo_rd),
        .valid_o   (m_valid_o),
        .rd_data_o (m_data_o),
        .rd_last_o (m_last_o),
        .count_o   (fifo_count)
    );

    assign busy_o              = (state_q == RUN) || (state_q == DRAIN);
    assign done_o              = (state_q == DONE);
    assign sram_en_o           = issue;
    assign sram_we_o           = 1'b0;
    assign sram_num_channels_o = desc_q.channels;

`ifdef SRAM_RD_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == IDLE) && start_i) begin
            perf_d = '0;
        end else if (busy_o && m_valid_o && !m_ready_i && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cycles_o = perf_q;
`endif

endmodule
